// File: rtl/mem_stage_access_unit.sv
// MEM stage: sized big-endian loads/stores over a req/ack bus, WB select and MEM/WB register.
// Latency: non-memory ops 0 stall cycles; memory ops stall 1 + ack wait (min 2).
// Backpressure: mem_stall holds the upstream pipeline; MEM_TIMEOUT_EN adds a BUSY abort.
module mem_stage_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_CNT_W       = 5
) (
  input  logic        clk,
  input  logic        R,
  input  logic [31:0] mem_alu_out,
  input  logic [31:0] mem_pc_d,
  input  logic [31:0] mem_sethi_imm22,
  input  logic [31:0] mem_store_data,
  input  logic [1:0]  mem_load,
  input  logic        mem_rf_le,
  input  logic [4:0]  mem_rd,
  input  logic        mem_e,
  input  logic [1:0]  mem_size,
  input  logic        mem_rw,
  input  logic        mem_se,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        mem_stall,
  output logic        misalign_trap,
  output logic        bus_err,
  output logic [31:0] mem_fwd_data,
  output logic [4:0]  wb_rd,
  output logic        wb_rf_le,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  k;
  logic        is_half, is_word, aligned, acc, misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic [31:0] load_buf;
  logic        to_expire;

  assign k          = mem_alu_out[1:0];
  assign is_half    = (mem_size == 2'b01);
  assign is_word    = mem_size[1];
  assign aligned    = !((is_half && k[0]) || (is_word && (k != 2'b00)));
  assign acc        = mem_e & aligned;
  assign misaligned = mem_e & ~aligned;

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = mem_store_data;
    if (is_word) begin
      be_calc    = 4'b1111;
      wdata_calc = mem_store_data;
    end else if (is_half) begin
      be_calc    = k[1] ? 4'b0011 : 4'b1100;
      wdata_calc = {2{mem_store_data[15:0]}};
    end else begin
      be_calc    = 4'b1000 >> k;
      wdata_calc = {4{mem_store_data[7:0]}};
    end
  end

  // Big-endian lanes: offset 0 is bits 31:24.
  always_comb begin
    lane_b = dm_rdata[31:24];
    case (k)
      2'd0: lane_b = dm_rdata[31:24];
      2'd1: lane_b = dm_rdata[23:16];
      2'd2: lane_b = dm_rdata[15:8];
      default: lane_b = dm_rdata[7:0];
    endcase
    lane_h = k[1] ? dm_rdata[15:0] : dm_rdata[31:16];
    if (is_word)
      load_ext = dm_rdata;
    else if (is_half)
      load_ext = {{16{mem_se & lane_h[15]}}, lane_h};
    else
      load_ext = {{24{mem_se & lane_b[7]}}, lane_b};
  end

  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    case (state)
      IDLE: begin
        mem_stall = acc;
        if (acc) state_nxt = BUSY;
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (dm_ack || to_expire) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state         <= IDLE;
      dm_req        <= 1'b0;
      dm_we         <= 1'b0;
      dm_addr       <= '0;
      dm_be         <= '0;
      dm_wdata      <= '0;
      load_buf      <= '0;
      misalign_trap <= 1'b0;
    end else begin
      state         <= state_nxt;
      misalign_trap <= (state == IDLE) && misaligned;
      if (state == IDLE && acc) begin
        dm_req   <= 1'b1;
        dm_we    <= mem_rw;
        dm_addr  <= {mem_alu_out[31:2], 2'b00};
        dm_be    <= be_calc;
        dm_wdata <= wdata_calc;
      end else if (state == BUSY && dm_ack) begin
        dm_req   <= 1'b0;
        dm_we    <= 1'b0;
        load_buf <= load_ext;
      end else if (state == BUSY && to_expire) begin
        dm_req   <= 1'b0;
        dm_we    <= 1'b0;
        load_buf <= '0;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TO_CNT_W-1:0] to_cnt;

  assign to_expire = (state == BUSY) && !dm_ack && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (R) begin
      to_cnt  <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= to_expire;
      if (state == BUSY && !dm_ack)
        to_cnt <= to_cnt + 1'b1;
      else
        to_cnt <= '0;
    end
  end
`else
  assign to_expire = 1'b0;
  assign bus_err   = 1'b0;
`endif

  // Load input is only meaningful in DONE, once the buffer holds this access.
  always_comb begin
    case (mem_load)
      2'b00:   mem_fwd_data = mem_alu_out;
      2'b01:   mem_fwd_data = load_buf;
      2'b10:   mem_fwd_data = mem_pc_d;
      default: mem_fwd_data = mem_sethi_imm22;
    endcase
  end

  // bus_err is high exactly in the DONE cycle of an aborted access.
  always_ff @(posedge clk) begin
    if (R || mem_stall) begin
      wb_rd    <= '0;
      wb_rf_le <= 1'b0;
      wb_data  <= '0;
    end else begin
      wb_rd    <= mem_rd;
      wb_rf_le <= mem_rf_le & ~misaligned & ~bus_err;
      wb_data  <= mem_fwd_data;
    end
  end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Bench for mem_stage_access_unit: vector table with a WB scoreboard plus reset/timeout sequences.
module tb_mem_stage_access_unit;

  localparam logic [31:0] PCD   = 32'h4000_0008;
  localparam logic [31:0] SETHI = 32'hABCD_E000;

  logic        clk = 1'b0;
  logic        R;
  logic [31:0] mem_alu_out, mem_pc_d, mem_sethi_imm22, mem_store_data;
  logic [1:0]  mem_load, mem_size;
  logic        mem_rf_le, mem_e, mem_rw, mem_se;
  logic [4:0]  mem_rd;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        mem_stall, misalign_trap, bus_err;
  logic [31:0] mem_fwd_data, wb_data;
  logic [4:0]  wb_rd;
  logic        wb_rf_le;

  always #5 clk = ~clk;

  mem_stage_access_unit #(.TIMEOUT_CYCLES(4), .TO_CNT_W(5)) dut (
    .clk(clk), .R(R),
    .mem_alu_out(mem_alu_out), .mem_pc_d(mem_pc_d), .mem_sethi_imm22(mem_sethi_imm22),
    .mem_store_data(mem_store_data), .mem_load(mem_load), .mem_rf_le(mem_rf_le),
    .mem_rd(mem_rd), .mem_e(mem_e), .mem_size(mem_size), .mem_rw(mem_rw), .mem_se(mem_se),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .mem_stall(mem_stall),
    .misalign_trap(misalign_trap), .bus_err(bus_err), .mem_fwd_data(mem_fwd_data),
    .wb_rd(wb_rd), .wb_rf_le(wb_rf_le), .wb_data(wb_data)
  );

  typedef struct {
    string       name;
    logic        e, rw, se, rf_le;
    logic [1:0]  size, load;
    logic [4:0]  rd;
    logic [31:0] alu, sdata, rdata;
    int          ack_wait, exp_stall;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_data;
    logic        exp_trap, exp_rf_le;
  } vec_t;

  typedef struct {
    logic        rf_le;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        trap;
  } wb_exp_t;

  wb_exp_t sb[$];
  vec_t    vecs[$];
  int      checks = 0;
  int      errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic e, input logic rw, input logic [1:0] size,
                              input logic se, input logic [1:0] load, input logic rf_le, input logic [4:0] rd,
                              input logic [31:0] alu, input logic [31:0] sdata, input int ack_wait,
                              input logic [31:0] rdata, input int exp_stall, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic exp_trap, input logic exp_rf_le,
                              input logic [31:0] exp_data);
    vec_t v;
    v.name = name; v.e = e; v.rw = rw; v.size = size; v.se = se; v.load = load; v.rf_le = rf_le;
    v.rd = rd; v.alu = alu; v.sdata = sdata; v.ack_wait = ack_wait; v.rdata = rdata;
    v.exp_stall = exp_stall; v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_trap = exp_trap;
    v.exp_rf_le = exp_rf_le; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    mem_alu_out = v.alu; mem_store_data = v.sdata; mem_load = v.load; mem_rf_le = v.rf_le;
    mem_rd = v.rd; mem_e = v.e; mem_size = v.size; mem_rw = v.rw; mem_se = v.se;
  endtask

  // Called at negedge+1; returns at negedge+1 after the WB register has captured the instruction.
  task automatic run_vec(input vec_t v);
    int      stalls, busy;
    wb_exp_t e, got;
    drive(v);
    e.rf_le = v.exp_rf_le; e.rd = v.rd; e.data = v.exp_data; e.trap = v.exp_trap;
    sb.push_back(e);
    stalls = 0; busy = 0;
    #1;
    while (mem_stall && stalls < 40) begin
      stalls++;
      if (dm_req) begin
        busy++;
        if (busy == 1) begin
          chk({v.name, " dm_addr"}, dm_addr, {v.alu[31:2], 2'b00});
          chk({v.name, " dm_be"}, 32'(dm_be), 32'(v.exp_be));
          chk({v.name, " dm_we"}, 32'(dm_we), 32'(v.rw));
          if (v.rw) chk({v.name, " dm_wdata"}, dm_wdata, v.exp_wdata);
        end
        dm_ack   = (busy == v.ack_wait);
        dm_rdata = dm_ack ? v.rdata : 32'h5A5A_5A5A;
      end
      @(negedge clk);
      dm_ack = 1'b0;
      #1;
    end
    chk({v.name, " stall_cycles"}, 32'(stalls), 32'(v.exp_stall));
    if (v.exp_rf_le) chk({v.name, " mem_fwd_data"}, mem_fwd_data, v.exp_data);
    @(negedge clk);
    #1;
    got.rf_le = wb_rf_le; got.rd = wb_rd; got.data = wb_data; got.trap = misalign_trap;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: empty queue", v.name);
    end else begin
      e = sb.pop_front();
      chk({v.name, " wb_rf_le"}, 32'(got.rf_le), 32'(e.rf_le));
      chk({v.name, " misalign_trap"}, 32'(got.trap), 32'(e.trap));
      chk({v.name, " dm_req_idle"}, 32'(dm_req), 32'd0);
      chk({v.name, " bus_err"}, 32'(bus_err), 32'd0);
      if (e.rf_le) begin
        chk({v.name, " wb_rd"}, 32'(got.rd), 32'(e.rd));
        chk({v.name, " wb_data"}, got.data, e.data);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int     stalls, busy, waited;
    logic   err_seen;
    vec_t   v;

    R = 1'b1; dm_ack = 1'b0; dm_rdata = '0;
    mem_pc_d = PCD; mem_sethi_imm22 = SETHI;
    mem_alu_out = '0; mem_store_data = '0; mem_load = 2'b00; mem_rf_le = 1'b0;
    mem_rd = '0; mem_e = 1'b0; mem_size = 2'b00; mem_rw = 1'b0; mem_se = 1'b0;

    //        name        e  rw size  se load  rf rd  alu           sdata         ack rdata         stl be       wdata         trp rfe data
    vecs.push_back(mk("alu",      0,0,2'b00,0,2'b00,1,5, 32'h0000_1234,32'h0,        0,32'h0,        0,4'b0000,32'h0,        0,1,32'h0000_1234));
    vecs.push_back(mk("ldb_se",   1,0,2'b00,1,2'b01,1,7, 32'h0000_0101,32'h0,        2,32'h11F2_2233,3,4'b0100,32'h0,        0,1,32'hFFFF_FFF2));
    vecs.push_back(mk("sth",      1,1,2'b01,0,2'b00,0,0, 32'h0000_0102,32'h0000_ABCD,1,32'h0,        2,4'b0011,32'hABCD_ABCD,0,0,32'h0));
    vecs.push_back(mk("ldw_mis",  1,0,2'b10,0,2'b01,1,8, 32'h0000_0006,32'h0,        0,32'h0,        0,4'b0000,32'h0,        1,0,32'h0));
    vecs.push_back(mk("ldb_zx",   1,0,2'b00,0,2'b01,1,9, 32'h0000_0203,32'h0,        1,32'h1234_56F7,2,4'b0001,32'h0,        0,1,32'h0000_00F7));
    vecs.push_back(mk("ldh_se",   1,0,2'b01,1,2'b01,1,10,32'h0000_0200,32'h0,        3,32'h8001_1234,4,4'b1100,32'h0,        0,1,32'hFFFF_8001));
    vecs.push_back(mk("ldh_zx",   1,0,2'b01,0,2'b01,1,11,32'h0000_0302,32'h0,        1,32'h1234_9ABC,2,4'b0011,32'h0,        0,1,32'h0000_9ABC));
    vecs.push_back(mk("ldw",      1,0,2'b10,1,2'b01,1,12,32'h0000_0400,32'h0,        1,32'hDEAD_BEEF,2,4'b1111,32'h0,        0,1,32'hDEAD_BEEF));
    vecs.push_back(mk("stb",      1,1,2'b00,0,2'b00,0,0, 32'h0000_0101,32'h1234_56A5,1,32'h0,        2,4'b0100,32'hA5A5_A5A5,0,0,32'h0));
    vecs.push_back(mk("sth_mis",  1,1,2'b01,0,2'b00,0,0, 32'h0000_0101,32'h0000_1111,0,32'h0,        0,4'b0000,32'h0,        1,0,32'h0));
    vecs.push_back(mk("pcd",      0,0,2'b00,0,2'b10,1,15,32'h0000_0055,32'h0,        0,32'h0,        0,4'b0000,32'h0,        0,1,PCD));
    vecs.push_back(mk("sethi",    0,0,2'b00,0,2'b11,1,16,32'h0000_0066,32'h0,        0,32'h0,        0,4'b0000,32'h0,        0,1,SETHI));
    vecs.push_back(mk("ldw_sz11", 1,0,2'b11,0,2'b01,1,17,32'h0000_0010,32'h0,        1,32'h0BAD_F00D,2,4'b1111,32'h0,        0,1,32'h0BAD_F00D));
    vecs.push_back(mk("ldb_k0",   1,0,2'b00,1,2'b01,1,18,32'h0000_0500,32'h0,        1,32'h7F00_0000,2,4'b1000,32'h0,        0,1,32'h0000_007F));
    vecs.push_back(mk("stw",      1,1,2'b10,0,2'b00,0,0, 32'h0000_0020,32'hCAFE_BABE,2,32'h0,        3,4'b1111,32'hCAFE_BABE,0,0,32'h0));
    vecs.push_back(mk("ldw_mis2", 1,0,2'b10,0,2'b01,1,19,32'h0000_0002,32'h0,        0,32'h0,        0,4'b0000,32'h0,        1,0,32'h0));

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst dm_req", 32'(dm_req), 32'd0);
    chk("rst dm_we", 32'(dm_we), 32'd0);
    chk("rst misalign_trap", 32'(misalign_trap), 32'd0);
    chk("rst bus_err", 32'(bus_err), 32'd0);
    chk("rst wb_rf_le", 32'(wb_rf_le), 32'd0);
    chk("rst wb_rd", 32'(wb_rd), 32'd0);
    chk("rst wb_data", wb_data, 32'd0);
    chk("rst mem_stall", 32'(mem_stall), 32'd0);
    R = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while BUSY, with acks arriving during and after reset
    v = mk("rst_busy", 1,0,2'b10,0,2'b01,1,20,32'h0000_0040,32'h0,0,32'h0,0,4'b0,32'h0,0,0,32'h0);
    drive(v);
    waited = 0;
    #1;
    while (!dm_req && waited < 10) begin
      @(negedge clk); #1; waited++;
    end
    chk("rst_busy reached_busy", 32'(dm_req), 32'd1);
    R = 1'b1; dm_ack = 1'b1; dm_rdata = 32'h1234_5678;
    @(negedge clk); #1;
    chk("rst_busy dm_req", 32'(dm_req), 32'd0);
    chk("rst_busy wb_rf_le", 32'(wb_rf_le), 32'd0);
    R = 1'b0; mem_e = 1'b0; mem_rf_le = 1'b0; mem_load = 2'b00;
    #1;
    chk("rst_busy idle_stall", 32'(mem_stall), 32'd0);
    @(negedge clk); dm_ack = 1'b0; #1;
    chk("rst_busy ack_ignored_req", 32'(dm_req), 32'd0);
    chk("rst_busy ack_ignored_wb", 32'(wb_rf_le), 32'd0);
    chk("rst_busy ack_ignored_stall", 32'(mem_stall), 32'd0);

    // Unacknowledged load: abort after 4 BUSY cycles, or wait indefinitely without the timeout
    v = mk("no_ack", 1,0,2'b10,0,2'b01,1,21,32'h0000_0080,32'h0,0,32'h0,0,4'b0,32'h0,0,0,32'h0);
    drive(v);
    stalls = 0; busy = 0; err_seen = 1'b0;
    #1;
    while (mem_stall && stalls < 60) begin
      stalls++;
      err_seen |= bus_err;
      if (dm_req) busy++;
`ifndef MEM_TIMEOUT_EN
      if (busy == 20) begin dm_ack = 1'b1; dm_rdata = 32'h600D_F00D; end
`endif
      @(negedge clk);
      dm_ack = 1'b0;
      #1;
    end
`ifdef MEM_TIMEOUT_EN
    chk("timeout stall_cycles", 32'(stalls), 32'd5);
    chk("timeout err_during_busy", 32'(err_seen), 32'd0);
    chk("timeout bus_err", 32'(bus_err), 32'd1);
    chk("timeout dm_req", 32'(dm_req), 32'd0);
    @(negedge clk); #1;
    chk("timeout wb_rf_le", 32'(wb_rf_le), 32'd0);
    chk("timeout bus_err_pulse", 32'(bus_err), 32'd0);
`else
    chk("long_wait stall_cycles", 32'(stalls), 32'd21);
    chk("long_wait bus_err", 32'(err_seen | bus_err), 32'd0);
    @(negedge clk); #1;
    chk("long_wait wb_rf_le", 32'(wb_rf_le), 32'd1);
    chk("long_wait wb_data", wb_data, 32'h600D_F00D);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_access_unit.md
Name: mem_stage_access_unit

Overview:
- MEM stage of the SPARC pipeline. Consumes the EX/MEM pipeline register outputs and performs data-memory loads and stores over a req/ack bus.
- Sizes: byte, halfword, word, big-endian, with optional sign extension on loads.
- Selects the writeback value, drives the MEM→WB register, and raises a stall while a memory access is in flight.

Parameters:
TIMEOUT_CYCLES, 16, max BUSY cycles before abort (used only with MEM_TIMEOUT_EN)
TO_CNT_W, 5, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock, all state on rising edge
R  in  1  reset; one clock; reset is synchronous and active-high
mem_alu_out  in  32  ALU result / effective address
mem_pc_d  in  32  PC_D (CALL link value)
mem_sethi_imm22  in  32  SETHI value
mem_store_data  in  32  store source operand
mem_load  in  2  WB select: 00 ALU, 01 load data, 10 PC_D, 11 SETHI
mem_rf_le  in  1  register-file write enable
mem_rd  in  5  destination register
mem_e  in  1  memory access enable
mem_size  in  2  00 byte, 01 half, 10/11 word
mem_rw  in  1  0 load, 1 store
mem_se  in  1  sign-extend load
dm_req  out  1  bus request (registered)
dm_we  out  1  bus write
dm_addr  out  32  word-aligned address {mem_alu_out[31:2],2'b00}
dm_be  out  4  byte enables, bit3 = bits 31:24
dm_wdata  out  32  store data, lane-replicated
dm_ack  in  1  bus completion, 1-cycle pulse
dm_rdata  in  32  read data, valid with dm_ack
mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
misalign_trap  out  1  1-cycle pulse on misaligned access
bus_err  out  1  1-cycle pulse on timeout abort
mem_fwd_data  out  32  combinational WB-mux value for forwarding
wb_rd  out  5  MEM/WB register
wb_rf_le  out  1  MEM/WB register
wb_data  out  32  MEM/WB register

Behaviour:
- Reset values:
  - state=IDLE.
  - dm_req, dm_we, misalign_trap, bus_err, wb_rf_le = 0.
  - wb_rd=0, wb_data=0, timeout counter=0, load buffer=0.
- Alignment:
  - half: misaligned if addr[0]=1.
  - word: misaligned if addr[1:0]≠0.
  - byte: always aligned.
- Access request: acc = mem_e & aligned.
- Byte lanes, offset k=addr[1:0]:
  - byte: be = 4'b1000>>k.
  - half: be = k[1]?0011:1100.
  - word: be = 1111.
- Store data replication: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- Load extraction:
  - Selected lane is right-justified.
  - Zero-filled if mem_se=0; sign-extended from lane MSB if mem_se=1.
- FSM:
  - IDLE: if acc → BUSY, set dm_req=1, dm_we=mem_rw, latch addr/be/wdata. mem_stall = acc (combinational).
  - BUSY: dm_req held 1, mem_stall=1. On dm_ack: capture the extracted load data into the buffer, drop dm_req, → DONE.
  - DONE: mem_stall=0; WB register loads this instruction and the load mux input uses the buffer; → IDLE.
- Latency:
  - Non-memory op: 0 stall cycles.
  - Memory op: stall cycles = 1 + ack wait; minimum 2 (ack on first BUSY cycle).
- dm_ack outside BUSY is ignored.
- WB register:
  - Each cycle with mem_stall=0 it loads rd, rf_le, and the WB-mux value.
  - With mem_stall=1 it loads a bubble (wb_rf_le=0, wb_rd=0, wb_data=0).
- Misaligned access:
  - No bus request, no stall.
  - misalign_trap=1 for the next cycle.
  - WB entry has wb_rf_le=0.
- mem_fwd_data: valid for loads only in DONE; valid for non-loads always.
- Reset mid-access:
  - R in BUSY/DONE → IDLE, dm_req=0 next edge.
  - In-flight ack is ignored and no WB write occurs.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined:
  - Counter increments each BUSY cycle without ack and clears in IDLE.
  - If it reaches TIMEOUT_CYCLES-1 without ack: drop dm_req, bus_err=1 next cycle, → DONE with load buffer=0 and wb_rf_le forced 0.
- Undefined: BUSY waits indefinitely; bus_err tied 0; counter absent.

Test Plan:
- ALU op, mem_e=0, mem_load=00, rd=5, alu_out=0x1234 → no stall; next cycle wb_rd=5, wb_rf_le=1, wb_data=0x1234.
- Load byte, se=1, addr=0x101, ack 2 cycles after req, rdata=0x11F22233 → mem_stall=1 for 3 cycles, dm_be=0100, wb_data=0xFFFFFFF2.
- Store half addr=0x102, data=0x0000ABCD, ack immediate → dm_we=1, dm_be=0011, dm_wdata=0xABCDABCD, dm_addr=0x100, wb_rf_le=0.
- Load word addr=0x006 → no dm_req, misalign_trap pulse, wb_rf_le=0, no stall.
- R asserted in BUSY, then dm_ack → dm_req=0 next edge, state IDLE, wb_rf_le=0, ack ignored.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → bus_err pulse after 4 BUSY cycles, stall released, wb_rf_le=0.
